led_cube_frame_scanner: RTL and testbench
=========================================

// Module: led_cube_frame_scanner
// PURPOSE
//  Downstream consumer of the UART byte poller. Assembles received bytes into a 64-byte frame:
//  8 layers x 8 rows, 1 bit per LED column.
//  Double-buffers the frame and continuously scans it onto the cube's latch/layer GPIO bus.
//  Sits between the UART poller (uart_reg + read strobe) and the GPIO_0 pin mapping.
// PARAMETERS
//  SYNC_BYTE      8'hA5  header byte that starts a frame
//  SETUP_CYCLES   2      cycles data_out is stable before a latch pulse
//  PULSE_CYCLES   2      latch strobe high time, in cycles
//  ON_CYCLES      50000  cycles each layer is lit (1 ms at 50 MHz)
//  TIMEOUT_CYCLES 500000 inter-byte timeout; used only with RX_TIMEOUT_EN
// PORTS
//  clock_sink_clk    in   1  clock
//  reset_sink_reset  in   1  synchronous reset, active-high
//  byte_data         in   8  received UART byte
//  byte_valid        in   1  one-cycle strobe; byte_data valid this cycle
//  scan_en           in   1  1 = scan cube; 0 = hold dark (receive continues)
//  layers_out        out  8  one-hot layer enable (bit n = layer n)
//  latches_out       out  8  one-hot row latch strobe (rising edge captures data_out)
//  data_out          out  8  row column data
//  rx_index          out  6  bytes received in current frame (debug)
//  frame_pending     out  1  complete frame in back buffer awaiting swap
//  frame_count       out  8  frames swapped to front buffer, wraps 255->0
// BEHAVIOUR
//  Reset:
//   - all outputs 0; front buffer cleared to 0; back buffer not cleared.
//   - RX in HUNT; scan in BLANK with layer=0, row=0.
//   - Reset mid-scan: outputs 0 the cycle after reset is sampled.
//  RX FSM, states HUNT / DATA:
//   - HUNT: byte_valid && byte_data==SYNC_BYTE -> DATA, rx_index=0. Other bytes are ignored.
//   - DATA: each byte_valid writes back[rx_index] and increments rx_index.
//     Index i maps to layer i[5:3], row i[2:0].
//   - SYNC_BYTE inside DATA is payload; there is no resync.
//   - Write of index 63: frame_pending<=1, rx_index<=0, -> HUNT.
//   - A new frame while frame_pending=1 overwrites the back buffer in place; latest data wins.
//     frame_pending stays 1.
//  Scan FSM, states BLANK -> SETUP -> LATCH -> HOLD -> (next row: SETUP | row 7 done: ON) -> BLANK:
//   - BLANK, 1 cycle: layers_out=0.
//     If layer==0 && frame_pending: copy back->front, clear frame_pending, frame_count++.
//     The swap lands only at a layer-0 boundary, so no tearing.
//   - SETUP, SETUP_CYCLES: data_out=front[{layer,row}], latches_out=0.
//   - LATCH, PULSE_CYCLES: latches_out=1<<row, data_out held.
//   - HOLD, 1 cycle: latches_out=0, data_out held. row++; after row 7, row wraps to 0 -> ON.
//   - ON, ON_CYCLES: layers_out=1<<layer, latches_out=0. Then layer++ (7->0 wraps) -> BLANK.
//   - Layer period = 1 + 8*(SETUP_CYCLES+PULSE_CYCLES+1) + ON_CYCLES cycles.
//   - layers_out is never nonzero while any latches_out bit is high.
//  Simultaneous events:
//   - The 63rd-byte write and a BLANK swap check in the same cycle: the swap uses the old pending
//     value, so the new frame swaps at the next layer-0 BLANK.
//  scan_en:
//   - scan_en=0: scan FSM is forced to BLANK with layer=0, row=0; outputs 0. RX is unaffected.
//   - Pending swaps still occur in BLANK.
//   - scan_en 0->1: scan resumes at BLANK, layer 0.
// CONFIGURATION
//  RX_TIMEOUT_EN defined:
//   - In DATA, an idle counter runs; byte_valid reloads it.
//   - After TIMEOUT_CYCLES with no byte: partial frame discarded, rx_index=0, -> HUNT.
//     frame_pending is unchanged.
//  RX_TIMEOUT_EN undefined:
//   - No counter; DATA waits indefinitely; TIMEOUT_CYCLES is ignored.
// TESTING
//  1 Reset held 3 cycles, then released; scan_en=1.
//    -> all outputs 0 during reset; first ON phase shows layers_out=8'h01, data_out 0 all rows.
//  2 Send A5, then 64 bytes of value i.
//    -> frame_pending=1.
//    -> At the next layer-0 BLANK: frame_count=1.
//    -> Layer 2 row 5 latch pulse: latches_out=8'h20, data_out=8'h15.
//  3 Send 11,22, then A5 plus 64 bytes.
//    -> 11,22 ignored; rx_index increments only after A5; frame loads correctly.
//  4 Send A5 plus 64 bytes with byte 10 = A5.
//    -> front[10]=A5; no resync; frame completes at byte 64.
//  5 With frame_pending=1, send a second full frame.
//    -> the second frame's data displays; frame_count increments once.
//  6 RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A5 plus 20 bytes, idle 101 cycles.
//    -> rx_index=0, HUNT; then a full frame loads normally.
//    -> Same stimulus without the macro: rx_index stays 20.

Source files
------------

// File: rtl/led_cube_frame_scanner.sv
// Receives 64-byte LED cube frames after a sync byte and scans a double-buffered copy onto the
// latch/layer bus. Optional macro RX_TIMEOUT_EN drops a partial frame after an inter-byte timeout.
module led_cube_frame_scanner #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         SETUP_CYCLES   = 2,
  parameter int         PULSE_CYCLES   = 2,
  parameter int         ON_CYCLES      = 50000,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic       clock_sink_clk,
  input  logic       reset_sink_reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       scan_en,
  output logic [7:0] layers_out,
  output logic [7:0] latches_out,
  output logic [7:0] data_out,
  output logic [5:0] rx_index,
  output logic       frame_pending,
  output logic [7:0] frame_count
);

  localparam int MAX_A = (ON_CYCLES > SETUP_CYCLES) ? ON_CYCLES : SETUP_CYCLES;
  localparam int MAX_C = (MAX_A > PULSE_CYCLES) ? MAX_A : PULSE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic {RX_HUNT, RX_DATA} rx_state_t;
  typedef enum logic [2:0] {SC_BLANK, SC_SETUP, SC_LATCH, SC_HOLD, SC_ON} scan_state_t;

  rx_state_t   rx_state;
  scan_state_t scan_state;
  logic [7:0]  back_buf  [64];
  logic [7:0]  front_buf [64];
  logic [2:0]  layer;
  logic [2:0]  row;
  logic [2:0]  row_next;
  logic [CNT_W-1:0] cnt;
  logic        swap;
  logic        rx_write;

  assign row_next = row + 3'd1;
  assign rx_write = (rx_state == RX_DATA) && byte_valid;
  // Swaps only at the top of layer 0 so a frame is never shown half old, half new.
  assign swap     = (scan_state == SC_BLANK) && (layer == 3'd0) && frame_pending;

  always_ff @(posedge clock_sink_clk) begin
    if (!reset_sink_reset && rx_write) back_buf[rx_index] <= byte_data;
  end

  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      for (int i = 0; i < 64; i++) front_buf[i] <= 8'h00;
    end else if (swap) begin
      for (int i = 0; i < 64; i++) front_buf[i] <= back_buf[i];
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] idle_cnt;
`endif

  // A completing write sets pending after the swap clear, so a frame finishing on a swap cycle waits.
  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      rx_state      <= RX_HUNT;
      rx_index      <= 6'd0;
      frame_pending <= 1'b0;
      frame_count   <= 8'd0;
`ifdef RX_TIMEOUT_EN
      idle_cnt      <= '0;
`endif
    end else begin
      if (swap) begin
        frame_pending <= 1'b0;
        frame_count   <= frame_count + 8'd1;
      end
      case (rx_state)
        RX_HUNT: begin
          if (byte_valid && byte_data == SYNC_BYTE) begin
            rx_state <= RX_DATA;
            rx_index <= 6'd0;
`ifdef RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        RX_DATA: begin
          if (byte_valid) begin
`ifdef RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (rx_index == 6'd63) begin
              frame_pending <= 1'b1;
              rx_index      <= 6'd0;
              rx_state      <= RX_HUNT;
            end else begin
              rx_index <= rx_index + 6'd1;
            end
          end
`ifdef RX_TIMEOUT_EN
          else if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rx_index <= 6'd0;
            rx_state <= RX_HUNT;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        default: rx_state <= RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset || !scan_en) begin
      scan_state  <= SC_BLANK;
      layer       <= 3'd0;
      row         <= 3'd0;
      cnt         <= '0;
      layers_out  <= 8'h00;
      latches_out <= 8'h00;
      data_out    <= 8'h00;
    end else begin
      case (scan_state)
        SC_BLANK: begin
          scan_state  <= SC_SETUP;
          cnt         <= '0;
          layers_out  <= 8'h00;
          latches_out <= 8'h00;
          data_out    <= swap ? back_buf[{layer, row}] : front_buf[{layer, row}];
        end
        SC_SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            scan_state  <= SC_LATCH;
            cnt         <= '0;
            latches_out <= 8'h01 << row;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SC_LATCH: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            scan_state  <= SC_HOLD;
            cnt         <= '0;
            latches_out <= 8'h00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SC_HOLD: begin
          row <= row_next;
          cnt <= '0;
          if (row == 3'd7) begin
            scan_state <= SC_ON;
            layers_out <= 8'h01 << layer;
          end else begin
            scan_state <= SC_SETUP;
            data_out   <= front_buf[{layer, row_next}];
          end
        end
        SC_ON: begin
          if (cnt == CNT_W'(ON_CYCLES - 1)) begin
            scan_state <= SC_BLANK;
            cnt        <= '0;
            layers_out <= 8'h00;
            layer      <= layer + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: scan_state <= SC_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_led_cube_frame_scanner.sv
// Randomized bench for led_cube_frame_scanner, checked every cycle against a position-in-frame
// model of the scan and a byte-level model of frame reception.
module tb_led_cube_frame_scanner;

  localparam int SETUP     = 2;
  localparam int PULSE     = 2;
  localparam int ON        = 20;
  localparam int TMO       = 100;
  localparam int ROW_LEN   = SETUP + PULSE + 1;
  localparam int LAYER_LEN = 1 + 8 * ROW_LEN + ON;
  localparam int FRAME_LEN = 8 * LAYER_LEN;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byteData;
  logic       byteValid;
  logic       scanEn;
  logic [7:0] layersOut, latchesOut, dataOut, frameCount;
  logic [5:0] rxIndex;
  logic       framePending;

  logic [7:0] mBack  [64];
  logic [7:0] mFront [64];
  bit         mPending;
  int         mCount, mIdx, mIdle, mPos;
  bit         mHunt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  led_cube_frame_scanner #(
    .SYNC_BYTE(8'hA5), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
    .ON_CYCLES(ON), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_sink_clk(clk), .reset_sink_reset(rst), .byte_data(byteData), .byte_valid(byteValid),
    .scan_en(scanEn), .layers_out(layersOut), .latches_out(latchesOut), .data_out(dataOut),
    .rx_index(rxIndex), .frame_pending(framePending), .frame_count(frameCount)
  );

  task automatic cmp8(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h pos=%0d", tag, observed, expected, mPos);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs the DUT samples at that edge.
  task automatic modelEdge();
    if (rst) begin
      for (int i = 0; i < 64; i++) mFront[i] = 8'h00;
      mPending = 0; mCount = 0; mHunt = 1; mIdx = 0; mIdle = 0; mPos = 0;
      return;
    end
    if (mPos == 0 && mPending) begin
      for (int i = 0; i < 64; i++) mFront[i] = mBack[i];
      mPending = 0;
      mCount = (mCount + 1) % 256;
    end
    if (mHunt) begin
      if (byteValid && byteData == 8'hA5) begin
        mHunt = 0; mIdx = 0; mIdle = 0;
      end
    end else if (byteValid) begin
      mBack[mIdx] = byteData;
      mIdle = 0;
      if (mIdx == 63) begin
        mPending = 1; mIdx = 0; mHunt = 1;
      end else begin
        mIdx++;
      end
    end else begin
`ifdef RX_TIMEOUT_EN
      mIdle++;
      if (mIdle == TMO) begin
        mHunt = 1; mIdx = 0;
      end
`endif
    end
    mPos = scanEn ? (mPos + 1) % FRAME_LEN : 0;
  endtask

  task automatic checkOutput();
    int lay, p, r, q;
    logic [7:0] expLayers, expLatches;
    bit rowPhase;
    lay = mPos / LAYER_LEN;
    p   = mPos % LAYER_LEN;
    r   = 0;
    expLayers = 8'h00; expLatches = 8'h00; rowPhase = 0;
    if (p >= 1 && p <= 8 * ROW_LEN) begin
      r = (p - 1) / ROW_LEN;
      q = (p - 1) % ROW_LEN;
      rowPhase = 1;
      if (q >= SETUP && q < SETUP + PULSE) expLatches = 8'(1 << r);
    end else if (p > 0) begin
      expLayers = 8'(1 << lay);
    end
    cmp8("layers_out", layersOut, expLayers);
    cmp8("latches_out", latchesOut, expLatches);
    if (rowPhase) cmp8("data_out", dataOut, mFront[lay * 8 + r]);
    cmp8("rx_index", {2'b00, rxIndex}, 8'(mIdx));
    cmp8("frame_pending", {7'd0, framePending}, {7'd0, mPending});
    cmp8("frame_count", frameCount, 8'(mCount));
    cmp8("latch_layer_overlap", {7'd0, (layersOut != 8'h00) && (latchesOut != 8'h00)}, 8'h00);
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d);
    byteValid = v;
    byteData  = d;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
    byteValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic sendByte(input logic [7:0] d, input int maxGap);
    idleCycles($urandom_range(0, maxGap));
    applyStimulus(1'b1, d);
  endtask

  // kind 0: byte i = i; kind 1: random; kind 2: random with byte 10 = sync value
  task automatic sendFrame(input int kind, input int maxGap);
    logic [7:0] b;
    sendByte(8'hA5, maxGap);
    for (int i = 0; i < 64; i++) begin
      b = (kind == 0) ? 8'(i) : 8'($urandom);
      if (kind == 2 && i == 10) b = 8'hA5;
      sendByte(b, maxGap);
    end
  endtask

  initial begin
    rst = 1'b1; byteValid = 1'b0; byteData = 8'h00; scanEn = 1'b1;
    for (int i = 0; i < 64; i++) mBack[i] = 8'hxx;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00);
      cmp8("data_out_reset", dataOut, 8'h00);
    end
    rst = 1'b0;
    $display("[TB] reset released, scanning blank frame");
    idleCycles(LAYER_LEN + 10);

    $display("[TB] counting-pattern frame");
    sendFrame(0, 2);
    idleCycles(FRAME_LEN + LAYER_LEN * 3);

    $display("[TB] junk before sync, then random frame");
    sendByte(8'h11, 2);
    sendByte(8'h22, 2);
    sendFrame(1, 3);
    idleCycles(FRAME_LEN + 40);

    $display("[TB] sync value inside payload");
    sendFrame(2, 1);
    idleCycles(FRAME_LEN + 40);

    $display("[TB] two frames while pending");
    idleCycles((FRAME_LEN - mPos + 2) % FRAME_LEN);
    sendFrame(1, 0);
    sendFrame(0, 0);
    idleCycles(FRAME_LEN * 2);

    $display("[TB] partial frame then idle");
    sendByte(8'hA5, 0);
    for (int i = 0; i < 20; i++) sendByte(8'($urandom), 1);
    idleCycles(TMO + 1);
`ifdef RX_TIMEOUT_EN
    cmp8("rx_index_after_idle", {2'b00, rxIndex}, 8'd0);
`else
    cmp8("rx_index_after_idle", {2'b00, rxIndex}, 8'd20);
`endif
`ifndef RX_TIMEOUT_EN
    for (int i = 0; i < 43; i++) sendByte(8'($urandom), 1);
`endif
    sendFrame(1, 2);
    idleCycles(FRAME_LEN + 40);

    $display("[TB] scan_en toggling with traffic");
    for (int k = 0; k < 6; k++) begin
      scanEn = 1'b0;
      idleCycles($urandom_range(1, 30));
      sendFrame(1, 1);
      idleCycles($urandom_range(1, 10));
      scanEn = 1'b1;
      idleCycles($urandom_range(50, 700));
    end

    $display("[TB] reset mid-scan");
    idleCycles(LAYER_LEN * 2 + 7);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00);
    cmp8("data_out_midreset", dataOut, 8'h00);
    applyStimulus(1'b0, 8'h00);
    rst = 1'b0;
    idleCycles(LAYER_LEN + 5);
    sendFrame(1, 1);
    idleCycles(FRAME_LEN + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
